// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush sequencer: load-use bubbles, redirect flushes and
// multi-cycle execute waits with a timeout guard and a saturating stall counter.
module hazard_sequencer #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdE,
    input  logic                 LoadE,
    input  logic                 PCSrcE,
    input  logic                 McStartE,
    input  logic                 McDoneE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic                 McBusy,
    output logic                 McTimeout,
    output logic [CNT_WIDTH-1:0] StallCycles
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] MC_LAST = 16'(MC_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_mc_cnt;
    logic [15:0]          w_mc_cnt_next;
    logic                 r_mc_timeout;
    logic                 w_set_timeout;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic                 w_load_use;

    assign w_load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= RUN;
            r_mc_cnt       <= 16'd0;
            r_mc_timeout   <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mc_cnt <= w_mc_cnt_next;
            if (w_set_timeout) begin
                r_mc_timeout <= 1'b1;
            end
            // Saturate rather than wrap so long runs never read as few stalls.
            if (StallF && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_mc_cnt_next = r_mc_cnt;
        w_set_timeout = 1'b0;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushM        = 1'b0;
        McBusy        = 1'b0;

        if (!reset) begin
            case (r_state)
                RUN: begin
                    if (PCSrcE) begin
                        // Decode instruction is squashed, so its hazard is moot.
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (McStartE && !McDoneE) begin
                        StallF        = 1'b1;
                        StallD        = 1'b1;
                        StallE        = 1'b1;
                        FlushM        = 1'b1;
                        w_state_next  = MC_WAIT;
                        w_mc_cnt_next = 16'd1;
                    end else if (McStartE && McDoneE) begin
                        w_state_next = RUN;
                    end else if (w_load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MC_WAIT: begin
                    McBusy = 1'b1;
                    if (!McDoneE && (r_mc_cnt < MC_LAST)) begin
                        StallF        = 1'b1;
                        StallD        = 1'b1;
                        StallE        = 1'b1;
                        FlushM        = 1'b1;
                        w_mc_cnt_next = r_mc_cnt + 16'd1;
                    end else begin
                        w_set_timeout = !McDoneE;
                        w_state_next  = RUN;
                        w_mc_cnt_next = 16'd0;
                    end
                end
                default: begin
                    w_state_next  = RUN;
                    w_mc_cnt_next = 16'd0;
                end
            endcase
        end
    end

    assign McTimeout   = r_mc_timeout;
    assign StallCycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized + directed bench for hazard_sequencer; a driver pushes expected
// per-cycle responses from a behavioural model, a monitor pops and compares.
module tb_hazard_sequencer;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_WIDTH  = 4;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic                 clk;
    logic                 reset;
    logic [4:0]           Rs1D, Rs2D, RdE;
    logic                 LoadE, PCSrcE, McStartE, McDoneE;
    logic                 StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy, McTimeout;
    logic [CNT_WIDTH-1:0] StallCycles;

    hazard_sequencer #(
        .MC_TIMEOUT(MC_TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdE        (RdE),
        .LoadE      (LoadE),
        .PCSrcE     (PCSrcE),
        .McStartE   (McStartE),
        .McDoneE    (McDoneE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .McBusy     (McBusy),
        .McTimeout  (McTimeout),
        .StallCycles(StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy}
    typedef struct {
        logic [6:0] flags;
        logic       tmo;
        int         cnt;
        int         idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cycle  = 0;

    // Reference state: stall cycles already spent by an outstanding multi-cycle
    // op (0 = none), the sticky timeout and the total stall count.
    int   m_mc_spent = 0;
    logic m_timeout  = 1'b0;
    int   m_stalls   = 0;

    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ld, input logic pc,
                        input logic st, input logic dn);
        exp_t       e;
        logic [6:0] f;
        logic       hazard;
        logic       timed_out;
        @(posedge clk);
        #1;
        reset = rst; Rs1D = rs1; Rs2D = rs2; RdE = rd;
        LoadE = ld; PCSrcE = pc; McStartE = st; McDoneE = dn;
        f         = 7'b0;
        timed_out = 1'b0;
        hazard    = ld && (rd != 0) && ((rd == rs1) || (rd == rs2));
        if (rst) begin
            m_mc_spent = 0;
            m_timeout  = 1'b0;
            m_stalls   = 0;
        end else if (m_mc_spent > 0) begin
            f[0] = 1'b1;
            if (dn) begin
                m_mc_spent = 0;
            end else if (m_mc_spent < MC_TIMEOUT - 1) begin
                f[6:4] = 3'b111; f[1] = 1'b1;
                m_mc_spent++;
            end else begin
                timed_out  = 1'b1;
                m_mc_spent = 0;
            end
        end else if (pc) begin
            f[3] = 1'b1; f[2] = 1'b1;
        end else if (st && !dn) begin
            f[6:4] = 3'b111; f[1] = 1'b1;
            m_mc_spent = 1;
        end else if (!st && hazard) begin
            f[6] = 1'b1; f[5] = 1'b1; f[2] = 1'b1;
        end
        e.flags = f;
        e.tmo   = m_timeout;
        e.cnt   = m_stalls;
        e.idx   = n_cycle;
        sb_q.push_back(e);
        n_cycle++;
        if (timed_out) m_timeout = 1'b1;
        if (f[6] && m_stalls < CNT_MAX) m_stalls++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle on the falling edge.
    initial begin
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy};
                n_checks++;
                if (act === e.flags) n_pass++;
                else $display("FAIL flags cyc=%0d actual=%b required=%b", e.idx, act, e.flags);
                n_checks++;
                if (McTimeout === e.tmo) n_pass++;
                else $display("FAIL McTimeout cyc=%0d actual=%b required=%b", e.idx, McTimeout, e.tmo);
                n_checks++;
                if (int'(StallCycles) == e.cnt && !$isunknown(StallCycles)) n_pass++;
                else $display("FAIL StallCycles cyc=%0d actual=%0d required=%0d", e.idx, StallCycles, e.cnt);
                $display("cyc=%0d flags=%b tmo=%b cnt=%0d", e.idx, act, McTimeout, StallCycles);
            end
        end
    end

    initial begin
        reset = 1'b1; Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
        LoadE = 1'b0; PCSrcE = 1'b0; McStartE = 1'b0; McDoneE = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Load-use, then load with RdE=0
        step(1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd9, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

        // Branch over a hazard
        step(1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Multi-cycle op, done on cycle 4
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Single-cycle completion
        step(1'b0, 5'd3, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);

        // Timeout with done never arriving; stray PCSrcE/LoadUse ignored meanwhile
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i < 10; i++) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // Reset mid-wait, then a normal multi-cycle op
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);

        // Saturation: LoadUse held for 20 cycles
        for (int i = 0; i < 20; i++) step(1'b0, 5'd2, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic, small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_ld, r_pc, r_st, r_dn;
            r_rst = ($urandom_range(0, 99) == 0);
            r_ld  = ($urandom_range(0, 2) == 0);
            r_pc  = ($urandom_range(0, 7) == 0);
            r_st  = ($urandom_range(0, 9) == 0);
            r_dn  = ($urandom_range(0, 5) == 0);
            step(r_rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), r_ld, r_pc, r_st, r_dn);
        end
        idle(1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain actual=%0d entries left required=0", sb_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
